// File: rtl/pipe_pkg.sv
// Shared Y86-64 pipeline constants: instruction codes, status codes, register ids.
// Also used by the pipeline control logic.
package pipe_pkg;

    localparam logic [3:0] HALT   = 4'h0;
    localparam logic [3:0] NOP    = 4'h1;
    localparam logic [3:0] CMOVXX = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] JXX    = 4'h7;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } d_reg_t;

    localparam d_reg_t D_BUBBLE = '{
        stat: SBUB, icode: NOP, ifun: 4'h0, ra: RNONE, rb: RNONE, valc: 64'h0, valp: 64'h0
    };

    function automatic logic needs_regids(input logic [3:0] icode);
        return icode inside {CMOVXX, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, PUSHQ, POPQ};
    endfunction

    function automatic logic needs_valc(input logic [3:0] icode);
        return icode inside {IRMOVQ, RMMOVQ, MRMOVQ, JXX, CALL};
    endfunction

endpackage

// File: rtl/pipe_fetch_align.sv
// Instruction byte aligner: splits the ten fetched bytes into decoded fields,
// need flags and a fetch status.
module pipe_fetch_align
    import pipe_pkg::*;
(
    input  logic [79:0] i_imem_data,
    input  logic        i_imem_error,
    output logic [3:0]  o_icode,
    output logic [3:0]  o_ifun,
    output logic [3:0]  o_ra,
    output logic [3:0]  o_rb,
    output logic [63:0] o_valc,
    output logic        o_need_regids,
    output logic        o_need_valc,
    output logic [2:0]  o_stat
);

    assign o_icode       = i_imem_error ? NOP : i_imem_data[7:4];
    assign o_ifun        = i_imem_error ? 4'h0 : i_imem_data[3:0];
    assign o_need_regids = needs_regids(o_icode);
    assign o_need_valc   = needs_valc(o_icode);
    assign o_ra          = o_need_regids ? i_imem_data[15:12] : RNONE;
    assign o_rb          = o_need_regids ? i_imem_data[11:8]  : RNONE;

    // The constant word shifts up one byte when a register specifier byte is present.
    assign o_valc = !o_need_valc  ? 64'h0 :
                    o_need_regids ? i_imem_data[79:16] : i_imem_data[71:8];

    always_comb begin
        if (i_imem_error)       o_stat = SADR;
        else if (o_icode > POPQ) o_stat = SINS;
        else if (o_icode == HALT) o_stat = SHLT;
        else                     o_stat = SAOK;
    end

endmodule

// File: rtl/pipe_fetch_stage.sv
// Fetch stage: PC selection with branch/return redirects, PC prediction and
// the decode pipeline register.
module pipe_fetch_stage
    import pipe_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    output logic [63:0] imem_addr,
    input  logic [79:0] imem_data,
    input  logic        imem_error,
    output logic [2:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP,
    output logic [63:0] f_predPC
);

    logic [63:0] r_pred_pc;
    d_reg_t      r_d;

    logic [63:0] w_f_pc;
    logic [63:0] w_valp;
    logic [3:0]  w_icode;
    logic [3:0]  w_ifun;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [63:0] w_valc;
    logic        w_need_regids;
    logic        w_need_valc;
    logic [2:0]  w_stat;

    pipe_fetch_align u_align (
        .i_imem_data   (imem_data),
        .i_imem_error  (imem_error),
        .o_icode       (w_icode),
        .o_ifun        (w_ifun),
        .o_ra          (w_ra),
        .o_rb          (w_rb),
        .o_valc        (w_valc),
        .o_need_regids (w_need_regids),
        .o_need_valc   (w_need_valc),
        .o_stat        (w_stat)
    );

    // A not-taken jump in M beats a return in W; both bypass F_stall.
    assign w_f_pc = (M_icode == JXX && !M_Cnd) ? M_valA :
                    (W_icode == RET)           ? W_valM : r_pred_pc;

    assign w_valp = w_f_pc + 64'd1 + {63'b0, w_need_regids} + (w_need_valc ? 64'd8 : 64'd0);

    assign imem_addr = w_f_pc;
    assign f_predPC  = (w_icode == JXX || w_icode == CALL) ? w_valc : w_valp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_pc <= RESET_PC;
        end else if (!F_stall) begin
            r_pred_pc <= f_predPC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d <= D_BUBBLE;
        end else if (D_stall) begin
            r_d <= r_d;
        end else if (D_bubble) begin
            r_d <= D_BUBBLE;
        end else begin
            r_d <= '{stat: w_stat, icode: w_icode, ifun: w_ifun, ra: w_ra, rb: w_rb,
                     valc: w_valc, valp: w_valp};
        end
    end

    assign D_stat  = r_d.stat;
    assign D_icode = r_d.icode;
    assign D_ifun  = r_d.ifun;
    assign D_rA    = r_d.ra;
    assign D_rB    = r_d.rb;
    assign D_valC  = r_d.valc;
    assign D_valP  = r_d.valp;

    // Stall wins when both are requested, but that combination indicates a control bug.
    a_stall_bubble_excl : assert property (@(posedge clk) disable iff (rst)
        !(D_stall && D_bubble));

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Self-checking bench for pipe_fetch_stage: a vector table plus hand sequences,
// decode-register expectations queued at drive time and checked a cycle later.
module tb_pipe_fetch_stage;
    import pipe_pkg::*;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } d_t;

    typedef struct {
        logic [79:0] data;
        logic        err;
        logic        fst;
        logic        dst;
        logic        dbub;
        logic [3:0]  mic;
        logic        mcnd;
        logic [63:0] mva;
        logic [3:0]  wic;
        logic [63:0] wvm;
        logic [63:0] e_addr;
        logic [63:0] e_pred;
        d_t          e_d;
    } vec_t;

    localparam logic [79:0] D_IRM  = 80'h0000000000000010F230;
    localparam logic [79:0] D_NOP  = 80'h00000000000000000010;
    localparam logic [79:0] D_J100 = 80'h00000000000000010070;
    localparam logic [79:0] D_C200 = 80'h00000000000000020080;
    localparam logic [79:0] D_OPQ  = 80'h00000000000000002360;
    localparam logic [79:0] D_RMM  = 80'h11223344556677881540;
    localparam logic [79:0] D_CMOV = 80'hDEADBEEFDEADBEEF4523;
    localparam logic [79:0] D_INS  = 80'h000000000000000000C0;
    localparam logic [79:0] D_HLT  = 80'h00000000000000000000;
    localparam logic [79:0] D_RET  = 80'h00000000000000000090;
    localparam logic [79:0] D_POP  = 80'h00000000000000003FB0;
    localparam logic [79:0] D_JFF  = 80'hFFFFFFFFFFFFFFFFFF70;

    logic        clk = 1'b0;
    logic        rst;
    logic        F_stall, D_stall, D_bubble;
    logic [3:0]  M_icode, W_icode;
    logic        M_Cnd;
    logic [63:0] M_valA, W_valM;
    logic [63:0] imem_addr;
    logic [79:0] imem_data;
    logic        imem_error;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [63:0] f_predPC;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];
    d_t   exp_q[$];

    pipe_fetch_stage #(.RESET_PC(64'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .F_stall    (F_stall),
        .D_stall    (D_stall),
        .D_bubble   (D_bubble),
        .M_icode    (M_icode),
        .M_Cnd      (M_Cnd),
        .M_valA     (M_valA),
        .W_icode    (W_icode),
        .W_valM     (W_valM),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_error (imem_error),
        .D_stat     (D_stat),
        .D_icode    (D_icode),
        .D_ifun     (D_ifun),
        .D_rA       (D_rA),
        .D_rB       (D_rB),
        .D_valC     (D_valC),
        .D_valP     (D_valP),
        .f_predPC   (f_predPC)
    );

    always #5 clk = ~clk;

    function automatic d_t d(input logic [2:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                             input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] valc,
                             input logic [63:0] valp);
        d_t r;
        r.stat = stat; r.icode = icode; r.ifun = ifun; r.ra = ra; r.rb = rb;
        r.valc = valc; r.valp = valp;
        return r;
    endfunction

    function automatic vec_t v(input logic [79:0] data, input logic err, input logic fst,
                               input logic dst, input logic dbub, input logic [3:0] mic,
                               input logic mcnd, input logic [63:0] mva, input logic [3:0] wic,
                               input logic [63:0] wvm, input logic [63:0] e_addr,
                               input logic [63:0] e_pred, input d_t e_d);
        vec_t r;
        r.data = data; r.err = err; r.fst = fst; r.dst = dst; r.dbub = dbub;
        r.mic = mic; r.mcnd = mcnd; r.mva = mva; r.wic = wic; r.wvm = wvm;
        r.e_addr = e_addr; r.e_pred = e_pred; r.e_d = e_d;
        return r;
    endfunction

    task automatic chk(input string name, input logic [150:0] act, input logic [150:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input string tag, input vec_t t);
        d_t got;
        d_t exp;
        imem_data = t.data; imem_error = t.err;
        F_stall = t.fst; D_stall = t.dst; D_bubble = t.dbub;
        M_icode = t.mic; M_Cnd = t.mcnd; M_valA = t.mva;
        W_icode = t.wic; W_valM = t.wvm;
        #1;
        chk({tag, " imem_addr"}, {87'b0, imem_addr}, {87'b0, t.e_addr});
        chk({tag, " f_predPC"}, {87'b0, f_predPC}, {87'b0, t.e_pred});
        exp_q.push_back(t.e_d);
        @(posedge clk);
        #1;
        got = {D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP};
        exp = exp_q.pop_front();
        chk({tag, " D_reg"}, got, exp);
    endtask

    initial begin
        d_t bub;
        bub = d(SBUB, NOP, 4'h0, RNONE, RNONE, 64'h0, 64'h0);

        // Table: PC chains from RESET_PC through each instruction class and redirect.
        vecs.push_back(v(D_IRM, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'h0, 64'hA,
                         d(SAOK, IRMOVQ, 0, RNONE, 4'h2, 64'h10, 64'hA)));
        vecs.push_back(v(D_NOP, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'hA, 64'hB,
                         d(SAOK, NOP, 0, RNONE, RNONE, 64'h0, 64'hB)));
        vecs.push_back(v(D_J100, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'hB, 64'h100,
                         d(SAOK, JXX, 0, RNONE, RNONE, 64'h100, 64'h14)));
        vecs.push_back(v(D_C200, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'h100, 64'h200,
                         d(SAOK, CALL, 0, RNONE, RNONE, 64'h200, 64'h109)));
        vecs.push_back(v(D_OPQ, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'h200, 64'h202,
                         d(SAOK, OPQ, 0, 4'h2, 4'h3, 64'h0, 64'h202)));
        vecs.push_back(v(D_RMM, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'h202, 64'h20C,
                         d(SAOK, RMMOVQ, 0, 4'h1, 4'h5, 64'h1122334455667788, 64'h20C)));
        vecs.push_back(v(D_CMOV, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'h20C, 64'h20E,
                         d(SAOK, CMOVXX, 4'h3, 4'h4, 4'h5, 64'h0, 64'h20E)));
        vecs.push_back(v(D_IRM, 1, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'h20E, 64'h20F,
                         d(SADR, NOP, 0, RNONE, RNONE, 64'h0, 64'h20F)));
        vecs.push_back(v(D_INS, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'h20F, 64'h210,
                         d(SINS, 4'hC, 0, RNONE, RNONE, 64'h0, 64'h210)));
        vecs.push_back(v(D_HLT, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'h210, 64'h211,
                         d(SHLT, HALT, 0, RNONE, RNONE, 64'h0, 64'h211)));
        vecs.push_back(v(D_RET, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'h211, 64'h212,
                         d(SAOK, RET, 0, RNONE, RNONE, 64'h0, 64'h212)));
        vecs.push_back(v(D_NOP, 0, 0, 0, 0, JXX, 0, 64'h29, NOP, 0, 64'h29, 64'h2A,
                         d(SAOK, NOP, 0, RNONE, RNONE, 64'h0, 64'h2A)));
        vecs.push_back(v(D_POP, 0, 1, 0, 0, NOP, 0, 0, RET, 64'h400, 64'h400, 64'h402,
                         d(SAOK, POPQ, 0, 4'h3, RNONE, 64'h0, 64'h402)));
        vecs.push_back(v(D_NOP, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'h2A, 64'h2B,
                         d(SAOK, NOP, 0, RNONE, RNONE, 64'h0, 64'h2B)));
        vecs.push_back(v(D_NOP, 0, 0, 0, 0, JXX, 0, 64'h500, RET, 64'h600, 64'h500, 64'h501,
                         d(SAOK, NOP, 0, RNONE, RNONE, 64'h0, 64'h501)));
        vecs.push_back(v(D_IRM, 0, 0, 1, 0, NOP, 0, 0, NOP, 0, 64'h501, 64'h50B,
                         d(SAOK, NOP, 0, RNONE, RNONE, 64'h0, 64'h501)));
        vecs.push_back(v(D_NOP, 0, 0, 0, 1, NOP, 0, 0, NOP, 0, 64'h50B, 64'h50C, bub));
        vecs.push_back(v(D_NOP, 0, 0, 0, 0, JXX, 1, 64'h999, NOP, 0, 64'h50C, 64'h50D,
                         d(SAOK, NOP, 0, RNONE, RNONE, 64'h0, 64'h50D)));

        // Reset with stalls asserted: reset must still load RESET_PC and the bubble.
        rst = 1'b1; F_stall = 1'b1; D_stall = 1'b1; D_bubble = 1'b0;
        M_icode = NOP; M_Cnd = 1'b0; M_valA = 64'h0; W_icode = NOP; W_valM = 64'h0;
        imem_data = D_NOP; imem_error = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset D_reg", {D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP}, bub);
        chk("reset imem_addr", {87'b0, imem_addr}, 151'h0);
        chk("reset f_predPC", {87'b0, f_predPC}, 151'h1);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Taken-path jump at 0x20, then a mispredict redirect to the fall-through 0x29.
        step("jxx_fetch", v(D_J100, 0, 0, 0, 0, JXX, 0, 64'h20, NOP, 0, 64'h20, 64'h100,
                            d(SAOK, JXX, 0, RNONE, RNONE, 64'h100, 64'h29)));
        step("jxx_pred", v(D_NOP, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'h100, 64'h101,
                           d(SAOK, NOP, 0, RNONE, RNONE, 64'h0, 64'h101)));
        step("jxx_redir", v(D_NOP, 0, 0, 0, 0, JXX, 0, 64'h29, NOP, 0, 64'h29, 64'h2A,
                            d(SAOK, NOP, 0, RNONE, RNONE, 64'h0, 64'h2A)));

        // Two-cycle decode stall holds D, then a bubble.
        step("dstall0", v(D_NOP, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'h2A, 64'h2B,
                          d(SAOK, NOP, 0, RNONE, RNONE, 64'h0, 64'h2B)));
        step("dstall1", v(D_IRM, 0, 0, 1, 0, NOP, 0, 0, NOP, 0, 64'h2B, 64'h35,
                          d(SAOK, NOP, 0, RNONE, RNONE, 64'h0, 64'h2B)));
        step("dstall2", v(D_IRM, 0, 0, 1, 0, NOP, 0, 0, NOP, 0, 64'h35, 64'h3F,
                          d(SAOK, NOP, 0, RNONE, RNONE, 64'h0, 64'h2B)));
        step("dbubble", v(D_NOP, 0, 0, 0, 1, NOP, 0, 0, NOP, 0, 64'h3F, 64'h40, bub));

        // Predicted PC of all ones wraps to zero.
        step("wrap_jmp", v(D_JFF, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'h40, 64'hFFFFFFFFFFFFFFFF,
                           d(SAOK, JXX, 0, RNONE, RNONE, 64'hFFFFFFFFFFFFFFFF, 64'h49)));
        step("wrap_nop", v(D_NOP, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'hFFFFFFFFFFFFFFFF, 64'h0,
                           d(SAOK, NOP, 0, RNONE, RNONE, 64'h0, 64'h0)));
        step("wrap_zero", v(D_NOP, 0, 0, 0, 0, NOP, 0, 0, NOP, 0, 64'h0, 64'h1,
                            d(SAOK, NOP, 0, RNONE, RNONE, 64'h0, 64'h1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_fetch_stage.md
PIPE_FETCH_STAGE -- requirements
Module: pipe_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC loaded into F_predPC on reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 F_stall, D_stall, D_bubble  in  1 each  controls from the pipeline control logic.
REQ-005 M_icode  in  4, M_Cnd  in  1, M_valA  in  64  mispredicted-branch redirect source.
REQ-006 W_icode  in  4, W_valM  in  64  return-address redirect source.
REQ-007 imem_addr  out  64  fetch address (f_pc), combinational.
REQ-008 imem_data  in  80  ten instruction bytes, byte0 in [7:0]; imem_error  in  1  invalid address.
REQ-009 D_stat  out  3, D_icode  out  4, D_ifun  out  4, D_rA  out  4, D_rB  out  4, D_valC  out  64, D_valP  out  64  registered decode-stage inputs.
REQ-010 f_predPC  out  64  next predicted PC (combinational, for debug and trace).

Function
REQ-011 f_pc SHALL be M_valA if M_icode==JXX and !M_Cnd; else W_valM if W_icode==RET; else F_predPC (registered), in that priority.
REQ-012 icode=byte0[7:4], ifun=byte0[3:0]; if imem_error, icode=NOP, ifun=0.
REQ-013 need_regids SHALL be true for icodes CMOVXX, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, PUSHQ, POPQ.
REQ-014 need_valC SHALL be true for IRMOVQ, RMMOVQ, MRMOVQ, JXX, CALL.
REQ-015 rA=byte1[7:4], rB=byte1[3:0] when need_regids, else both 4'hF (RNONE).
REQ-016 valC SHALL be little-endian bytes 2..9 if need_regids, else bytes 1..8; 0 when !need_valC.
REQ-017 valP = f_pc + 1 + need_regids + 8*need_valC, 64-bit modulo wrap.
REQ-018 f_predPC = valC for JXX and CALL, else valP.
REQ-019 stat priority: imem_error -> SADR; icode > 4'hB -> SINS; icode==HALT -> SHLT; else SAOK.
REQ-020 F_predPC SHALL load f_predPC each cycle unless F_stall (hold).
REQ-021 D register: D_stall -> hold all fields; else D_bubble -> load bubble; else load fetched fields; latency one cycle.
REQ-022 Bubble value: stat SBUB, icode NOP, ifun 0, rA=rB=RNONE, valC=0, valP=0.
REQ-023 D_stall and D_bubble both asserted SHALL be treated as stall (hold); simulation assertion flags it.
REQ-024 Redirects (REQ-011) SHALL take effect in the same cycle regardless of F_stall.

Reset
REQ-025 On rst: F_predPC=RESET_PC; D register = bubble value (REQ-022); rst overrides stall and bubble.
REQ-026 Deassertion: first fetch from RESET_PC on the cycle rst is low, D valid next edge.

Structure
REQ-027 Icode constants (HALT..POPQ), stat codes (SBUB=0, SAOK=1, SHLT=2, SADR=3, SINS=4), RNONE in shared package pipe_pkg, also used by the control logic.
REQ-028 One combinational sub-module pipe_fetch_align: imem_data + imem_error -> icode, ifun, rA, rB, valC, need flags, stat.
REQ-029 State limited to F_predPC and D register; no other storage.

Verification
REQ-030 Reset, imem_data = irmovq (30 F2 + 8-byte 0x10) at PC 0 -> D_icode=3, D_rB=2, D_valC=0x10, D_valP=10, F_predPC=10.
REQ-031 jXX at PC 0x20 with valC=0x100 -> F_predPC=0x100; next cycle M_icode=7, M_Cnd=0, M_valA=0x29 -> imem_addr=0x29.
REQ-032 W_icode=RET, W_valM=0x400 with F_stall=1 -> imem_addr=0x400, F_predPC unchanged.
REQ-033 D_stall=1 two cycles -> D outputs constant; D_bubble=1 -> D_stat=SBUB, D_icode=NOP next edge.
REQ-034 imem_error=1 -> D_stat=SADR, D_icode=NOP; byte0=0xC0 -> D_stat=SINS; byte0=0x00 -> SHLT.
REQ-035 F_predPC=64'hFFFF_FFFF_FFFF_FFFF, nop fetched -> f_predPC=0 (wrap).
